// File: rtl/rr_tag_arbiter.sv
// Round-robin arbiter that offers one requester's item downstream, tagged idx+1.
// Optional offer-abandon timeout enabled by defining RR_TAG_ARB_TIMEOUT_EN.
module rr_tag_arbiter #(
  parameter int N       = 4,
  parameter int TAG_SZ  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      rdys,
  output logic [N-1:0]      acks,
  output logic [TAG_SZ-1:0] tag,
  output logic              rdy,
  input  logic              ack
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 16 || (1 << TAG_SZ) <= N || TIMEOUT < 1) begin : g_param_check
    $error("rr_tag_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, OFFER} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx_next;

  // First set request starting at ptr, wrapping modulo N.
  always_comb begin
    sel = ptr;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned p;
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (rdys[IW'(p)]) begin
        sel = IW'(p);
        break;
      end
    end
  end

  assign idx_next = (int'(idx) == N - 1) ? '0 : idx + IW'(1);

  assign rdy = (state == OFFER) && rdys[idx];
  assign tag = rdy ? TAG_SZ'(idx) + TAG_SZ'(1) : '0;

  always_comb begin
    acks = '0;
    if (rdy && ack) acks[idx] = 1'b1;
  end

`ifdef RR_TAG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|rdys) begin
            idx   <= sel;
            state <= OFFER;
          end
        end
        OFFER: begin
          if (!rdys[idx]) begin
            state <= IDLE;
          end else if (ack || cnt == CW'(TIMEOUT - 1)) begin
            // Ack in the last counted cycle and timeout both advance the pointer.
            state <= IDLE;
            ptr   <= idx_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|rdys) begin
            idx   <= sel;
            state <= OFFER;
          end
        end
        OFFER: begin
          if (!rdys[idx]) begin
            state <= IDLE;
          end else if (ack) begin
            state <= IDLE;
            ptr   <= idx_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: doc/rr_tag_arbiter.md
RR_TAG_ARBITER -- requirements
Module: rr_tag_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..16).
REQ-002 Parameter TAG_SZ, default 5, tag width; SHALL satisfy 2^TAG_SZ > N.
REQ-003 Parameter TIMEOUT, default 16, offer-abandon limit in cycles (used only under REQ-024).
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-006 rdys  input  N  per-requester ready; bit i means requester i has an item.
REQ-007 acks  output  N  per-requester acknowledge; one-hot or zero.
REQ-008 tag  output  TAG_SZ  granted requester's tag, i+1; 0 when none.
REQ-009 rdy  output  1  offer valid toward the downstream consumer.
REQ-010 ack  input  1  downstream acknowledge; the transfer completes in any cycle with rdy=1 and ack=1.

Function
REQ-011 Two-state FSM, IDLE and OFFER, plus index register idx (clog2(N) bits) and round-robin pointer ptr (clog2(N) bits).
REQ-012 IDLE with rdys==0: remain in IDLE.
REQ-013 IDLE with rdys!=0: latch idx = first set bit searching ptr, ptr+1, ... wrapping mod N; next state OFFER. Latency from rdys rising to rdy=1 is exactly 1 cycle.
REQ-014 rdy = (state==OFFER) && rdys[idx], combinational.
REQ-015 tag = idx+1 when rdy=1, else 0.
REQ-016 acks[idx] = rdy && ack, combinational; all other acks bits are 0.
REQ-017 OFFER with rdy && ack: next state IDLE; ptr <= (idx+1) mod N.
REQ-018 OFFER with rdys[idx]=0 (requester withdrew): next state IDLE; ptr unchanged; no ack issued.
REQ-019 OFFER with rdy=1 and ack=0: hold; idx and tag stay stable.
REQ-020 Changes to rdys bits other than idx during OFFER have no effect until the next IDLE.
REQ-021 Back-to-back grants: minimum 2 cycles per transfer (OFFER then IDLE re-arbitration).
REQ-022 ack while in IDLE is ignored; acks stays 0.

Reset
REQ-023 While rst=0, independent of clk: state=IDLE, idx=0, ptr=0, so rdy=0, tag=0, acks=0. Reset asserted mid-OFFER drops rdy in the same cycle. After rst returns to 1, the first arbitration starts from requester 0.

Configuration
REQ-024 Macro RR_TAG_ARB_TIMEOUT_EN. When defined: an offer counter clears on entry to OFFER and increments each OFFER cycle without ack. When the counter reaches TIMEOUT-1 with no ack, the FSM returns to IDLE on the next edge, sets ptr <= (idx+1) mod N, and issues no ack. An ack in the final counted cycle wins over the timeout.
REQ-025 When RR_TAG_ARB_TIMEOUT_EN is undefined: no counter exists and OFFER holds indefinitely per REQ-019.

Verification
REQ-026 Reset: rst=0 with rdys=4'b1111 -> rdy=0, tag=0, acks=0 throughout; release -> next cycle rdy=1, tag=1.
REQ-027 Round-robin: rdys=4'b1111, ack=1 constant -> tags 1,2,3,4,1 on successive offers every 2 cycles; acks pulse 0001,0010,0100,1000.
REQ-028 Wrap and skip: ptr=3, rdys=4'b0101 -> tag=1 granted, then tag=3.
REQ-029 Withdrawal: OFFER tag=2, rdys[1] falls with ack=0 -> rdy=0 that cycle, acks=0, next grant from the same pointer.
REQ-030 Hold: ack=0 for 10 cycles with rdys=4'b0011 -> tag stays 1 and stable; ack=1 -> acks=0001 in that cycle.
REQ-031 With RR_TAG_ARB_TIMEOUT_EN, TIMEOUT=4, rdys=4'b0011, ack=0 -> tag=1 for 4 cycles, IDLE, then tag=2; without the macro -> tag=1 indefinitely.
